// File: rtl/snoop_inj_pkg.sv
// -----------------------------------------------------------------------------
// snoop_inj_pkg
// Shared types and constants for the snoop fault injector:
//   - state_e       : responder FSM states (also exported on o_state)
//   - MODE_*        : injection mode encodings for i_mode
//   - CR_*          : bit positions inside the ACE CRRESP field
// -----------------------------------------------------------------------------
package snoop_inj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_DELAY  = 3'd2,
    ST_RESP   = 3'd3,
    ST_DATA   = 3'd4
  } state_e;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_NSHOT   = 2'd2;
  localparam logic [1:0] MODE_CONT    = 2'd3;

  localparam int CR_DATA_TRANSFER = 0;
  localparam int CR_ERROR         = 1;
  localparam int CR_PASS_DIRTY    = 2;
  localparam int CR_IS_SHARED     = 3;
  localparam int CR_WAS_UNIQUE    = 4;

endpackage

// File: rtl/snoop_region_match.sv
// -----------------------------------------------------------------------------
// snoop_region_match
// Combinational NUM_REGIONS-way address window compare on a 32-bit address.
// A window hits when it is enabled and base <= addr < base + size. The upper
// bound is formed in 33 bits so a window near the top of the space never
// wraps to low addresses; size 0 can never hit.
// Ports:
//   addr_i     : address to test (snoop address bits [31:0])
//   base_i     : packed window bases, 32 bits per region
//   size_i     : packed window sizes, 32 bits per region
//   en_i       : per-window enable
//   hit_o      : per-window hit vector
//   any_hit_o  : OR of hit_o
// -----------------------------------------------------------------------------
module snoop_region_match
  import snoop_inj_pkg::*;
#(
  parameter int NUM_REGIONS = 4
) (
  input  logic [31:0]               addr_i,
  input  logic [NUM_REGIONS*32-1:0] base_i,
  input  logic [NUM_REGIONS*32-1:0] size_i,
  input  logic [NUM_REGIONS-1:0]    en_i,
  output logic [NUM_REGIONS-1:0]    hit_o,
  output logic                      any_hit_o
);

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
    logic [32:0] lo;
    logic [32:0] hi;
    assign lo       = {1'b0, base_i[r*32 +: 32]};
    assign hi       = lo + {1'b0, size_i[r*32 +: 32]};
    assign hit_o[r] = en_i[r] && ({1'b0, addr_i} >= lo) && ({1'b0, addr_i} < hi);
  end

  assign any_hit_o = |hit_o;

endmodule

// File: rtl/snoop_fault_injector.sv
// -----------------------------------------------------------------------------
// snoop_fault_injector
// ACE snoop-channel responder. Every AC request gets a CR response; requests
// that hit an enabled address window and the snoop-type filter receive an
// injected response (programmable CRRESP, delay and data pattern) in one-shot,
// N-shot or continuous mode. Everything else gets a clean immediate reply.
// Only one snoop is ever outstanding.
//
// Optional feature (macro SNOOP_INJ_LATENCY_STATS_EN): when defined,
// o_max_latency tracks the largest AC-handshake to CR-handshake distance in
// cycles (saturating, cleared on reset or a falling i_enable). When undefined,
// o_max_latency is tied to zero.
//
// Ports:
//   ace_aclk, ace_areset         : clock, synchronous active-high reset
//   acvalid/acready/acaddr/acsnoop : AC snoop request channel
//   crvalid/crready/crresp       : CR snoop response channel
//   cdvalid/cdready/cddata/cdlast : CD snoop data channel
//   i_enable, i_mode, i_shot_count : injection control
//   i_crresp, i_delay, i_data_pattern : injected response contents
//   i_snoop_match(_en)           : snoop-type filter
//   i_region_base/size/en        : address windows on acaddr[31:0]
//   o_done, o_inject_count       : shot budget status / injected count
//   o_state                      : FSM state for debug
//   o_max_latency                : worst-case snoop latency (optional)
// -----------------------------------------------------------------------------
module snoop_fault_injector
  import snoop_inj_pkg::*;
#(
  parameter int C_ACE_ADDR_WIDTH = 44,
  parameter int C_ACE_DATA_WIDTH = 128,
  parameter int LINE_BYTES       = 64,
  parameter int NUM_REGIONS      = 4,
  parameter int DELAY_WIDTH      = 16,
  parameter int SHOT_WIDTH       = 8
) (
  input  logic                        ace_aclk,
  input  logic                        ace_areset,
  input  logic                        acvalid,
  output logic                        acready,
  input  logic [C_ACE_ADDR_WIDTH-1:0] acaddr,
  input  logic [3:0]                  acsnoop,
  output logic                        crvalid,
  input  logic                        crready,
  output logic [4:0]                  crresp,
  output logic                        cdvalid,
  input  logic                        cdready,
  output logic [C_ACE_DATA_WIDTH-1:0] cddata,
  output logic                        cdlast,
  input  logic                        i_enable,
  input  logic [1:0]                  i_mode,
  input  logic [SHOT_WIDTH-1:0]       i_shot_count,
  input  logic [4:0]                  i_crresp,
  input  logic [DELAY_WIDTH-1:0]      i_delay,
  input  logic [31:0]                 i_data_pattern,
  input  logic [3:0]                  i_snoop_match,
  input  logic                        i_snoop_match_en,
  input  logic [NUM_REGIONS*32-1:0]   i_region_base,
  input  logic [NUM_REGIONS*32-1:0]   i_region_size,
  input  logic [NUM_REGIONS-1:0]      i_region_en,
  output logic                        o_done,
  output logic [SHOT_WIDTH-1:0]       o_inject_count,
  output logic [2:0]                  o_state,
  output logic [DELAY_WIDTH+1:0]      o_max_latency
);

  localparam int BEATS  = LINE_BYTES * 8 / C_ACE_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Line data: pattern replicated across the beat, beat index in byte 0.
  function automatic logic [C_ACE_DATA_WIDTH-1:0] beat_data(input logic [31:0]       pat,
                                                          input logic [BEAT_W-1:0] beat);
    logic [C_ACE_DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < C_ACE_DATA_WIDTH; i++) d[i] = pat[i % 32];
    d[7:0] = 8'(beat);
    return d;
  endfunction

  // Control / output registers
  state_e                      state_q;
  logic                        acready_q;
  logic                        crvalid_q;
  logic [4:0]                  crresp_q;
  logic                        cdvalid_q;
  logic                        cdlast_q;
  logic [C_ACE_DATA_WIDTH-1:0] cddata_q;
  logic                        done_q;
  logic [SHOT_WIDTH-1:0]       inj_cnt_q;
  logic [DELAY_WIDTH-1:0]      dly_cnt_q;
  logic [BEAT_W-1:0]           beat_q;
  logic                        inj_q;

  // Request and configuration snapshot taken at the AC handshake
  logic [31:0]               addr_q;
  logic [3:0]                snoop_q;
  logic                      cfg_en_q;
  logic [1:0]                cfg_mode_q;
  logic [SHOT_WIDTH-1:0]     cfg_shot_q;
  logic [4:0]                cfg_crresp_q;
  logic [DELAY_WIDTH-1:0]    cfg_delay_q;
  logic [31:0]               cfg_pat_q;
  logic [3:0]                cfg_match_q;
  logic                      cfg_match_en_q;
  logic [NUM_REGIONS*32-1:0] cfg_base_q;
  logic [NUM_REGIONS*32-1:0] cfg_size_q;
  logic [NUM_REGIONS-1:0]    cfg_region_en_q;

  logic                      ac_hs_d;
  logic [NUM_REGIONS-1:0]    region_hit_d;
  logic                      any_hit_d;
  logic                      snoop_hit_d;
  logic                      shot_zero_d;
  logic                      inject_d;
  logic [DELAY_WIDTH:0]      dly_next_d;
  logic [BEAT_W-1:0]         beat_next_d;
  logic [SHOT_WIDTH-1:0]     inj_inc_d;
  logic                      unused_addr_hi;

  // Only addr[31:0] takes part in window matching.
  assign unused_addr_hi = ^acaddr[C_ACE_ADDR_WIDTH-1:32];

  assign ac_hs_d = (state_q == ST_IDLE) && acvalid && acready_q;

  always_ff @(posedge ace_aclk) begin
    if (ac_hs_d) begin
      addr_q          <= acaddr[31:0];
      snoop_q         <= acsnoop;
      cfg_en_q        <= i_enable;
      cfg_mode_q      <= i_mode;
      cfg_shot_q      <= i_shot_count;
      cfg_crresp_q    <= i_crresp;
      cfg_delay_q     <= i_delay;
      cfg_pat_q       <= i_data_pattern;
      cfg_match_q     <= i_snoop_match;
      cfg_match_en_q  <= i_snoop_match_en;
      cfg_base_q      <= i_region_base;
      cfg_size_q      <= i_region_size;
      cfg_region_en_q <= i_region_en;
    end
  end

  snoop_region_match #(
    .NUM_REGIONS (NUM_REGIONS)
  ) u_region_match (
    .addr_i    (addr_q),
    .base_i    (cfg_base_q),
    .size_i    (cfg_size_q),
    .en_i      (cfg_region_en_q),
    .hit_o     (region_hit_d),
    .any_hit_o (any_hit_d)
  );

  assign snoop_hit_d = !cfg_match_en_q || (snoop_q == cfg_match_q);
  // N-shot with a zero budget is exhausted before it starts.
  assign shot_zero_d = (cfg_mode_q == MODE_NSHOT) && (cfg_shot_q == '0);
  assign inject_d    = cfg_en_q && (cfg_mode_q != MODE_OFF) && !done_q && !shot_zero_d
                       && any_hit_d && snoop_hit_d;
  assign dly_next_d  = {1'b0, dly_cnt_q} + (DELAY_WIDTH + 1)'(1);
  assign beat_next_d = beat_q + BEAT_W'(1);
  assign inj_inc_d   = (&inj_cnt_q) ? inj_cnt_q : inj_cnt_q + SHOT_WIDTH'(1);

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      state_q   <= ST_IDLE;
      acready_q <= 1'b0;
      crvalid_q <= 1'b0;
      crresp_q  <= '0;
      cdvalid_q <= 1'b0;
      cdlast_q  <= 1'b0;
      cddata_q  <= '0;
      done_q    <= 1'b0;
      inj_cnt_q <= '0;
      dly_cnt_q <= '0;
      beat_q    <= '0;
      inj_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acvalid && acready_q) begin
            acready_q <= 1'b0;
            state_q   <= ST_FILTER;
          end else begin
            acready_q <= 1'b1;
          end
        end
        ST_FILTER: begin
          inj_q     <= inject_d;
          dly_cnt_q <= '0;
          if (inject_d) begin
            crresp_q <= cfg_crresp_q;
            // Zero delay goes straight to the response with no extra cycle.
            if (cfg_delay_q == '0) begin
              crvalid_q <= 1'b1;
              state_q   <= ST_RESP;
            end else begin
              state_q <= ST_DELAY;
            end
          end else begin
            crresp_q  <= '0;
            crvalid_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_DELAY: begin
          // Leave one cycle early so crvalid is registered on the D-th cycle.
          if (dly_next_d == {1'b0, cfg_delay_q}) begin
            crvalid_q <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            dly_cnt_q <= dly_next_d[DELAY_WIDTH-1:0];
          end
        end
        ST_RESP: begin
          if (crready) begin
            crvalid_q <= 1'b0;
            if (crresp_q[CR_DATA_TRANSFER]) begin
              cdvalid_q <= 1'b1;
              beat_q    <= '0;
              cddata_q  <= beat_data(cfg_pat_q, '0);
              cdlast_q  <= (BEATS == 1);
              state_q   <= ST_DATA;
            end else begin
              acready_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (cdready) begin
            if (cdlast_q) begin
              cdvalid_q <= 1'b0;
              cdlast_q  <= 1'b0;
              acready_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              beat_q   <= beat_next_d;
              cddata_q <= beat_data(cfg_pat_q, beat_next_d);
              cdlast_q <= (beat_next_d == LAST_BEAT);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Shot accounting; a low enable level wipes the budget state.
      if (!i_enable) begin
        done_q    <= 1'b0;
        inj_cnt_q <= '0;
      end else begin
        if ((state_q == ST_FILTER) && cfg_en_q && shot_zero_d) done_q <= 1'b1;
        if ((state_q == ST_RESP) && crready && inj_q) begin
          inj_cnt_q <= inj_inc_d;
          if (cfg_mode_q == MODE_ONESHOT) done_q <= 1'b1;
          else if ((cfg_mode_q == MODE_NSHOT) && (inj_inc_d >= cfg_shot_q)) done_q <= 1'b1;
        end
      end
    end
  end

`ifdef SNOOP_INJ_LATENCY_STATS_EN
  localparam int LAT_W = DELAY_WIDTH + 2;

  logic [LAT_W-1:0] lat_cnt_q;
  logic [LAT_W-1:0] max_lat_q;
  logic             en_prev_q;

  // lat_cnt_q equals cycles since the AC handshake while the snoop is open.
  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      lat_cnt_q <= '0;
      max_lat_q <= '0;
      en_prev_q <= 1'b0;
    end else begin
      en_prev_q <= i_enable;
      if (ac_hs_d) lat_cnt_q <= LAT_W'(1);
      else if (!(&lat_cnt_q)) lat_cnt_q <= lat_cnt_q + LAT_W'(1);
      if (en_prev_q && !i_enable) max_lat_q <= '0;
      else if ((state_q == ST_RESP) && crready && (lat_cnt_q > max_lat_q)) max_lat_q <= lat_cnt_q;
    end
  end

  assign o_max_latency = max_lat_q;
`else
  assign o_max_latency = '0;
`endif

  assign acready        = acready_q;
  assign crvalid        = crvalid_q;
  assign crresp         = crresp_q;
  assign cdvalid        = cdvalid_q;
  assign cdlast         = cdlast_q;
  assign cddata         = cddata_q;
  assign o_done         = done_q;
  assign o_inject_count = inj_cnt_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_snoop_fault_injector.sv
// -----------------------------------------------------------------------------
// tb_snoop_fault_injector
// Scoreboard bench: each snoop pushes its expected CRRESP and data pattern;
// a negedge monitor pops on every CR handshake and checks the CD beats.
// -----------------------------------------------------------------------------
module tb_snoop_fault_injector;

  localparam int AW = 44;
  localparam int DW = 128;
  localparam int NR = 4;
  localparam int DLW = 16;
  localparam int SW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            acvalid, acready;
  logic [AW-1:0]   acaddr;
  logic [3:0]      acsnoop;
  logic            crvalid, crready;
  logic [4:0]      crresp;
  logic            cdvalid, cdready, cdlast;
  logic [DW-1:0]   cddata;
  logic            i_enable;
  logic [1:0]      i_mode;
  logic [SW-1:0]   i_shot_count;
  logic [4:0]      i_crresp;
  logic [DLW-1:0]  i_delay;
  logic [31:0]     i_data_pattern;
  logic [3:0]      i_snoop_match;
  logic            i_snoop_match_en;
  logic [NR*32-1:0] i_region_base, i_region_size;
  logic [NR-1:0]   i_region_en;
  logic            o_done;
  logic [SW-1:0]   o_inject_count;
  logic [2:0]      o_state;
  logic [DLW+1:0]  o_max_latency;

  always #5 clk = ~clk;

  snoop_fault_injector dut (
    .ace_aclk         (clk),
    .ace_areset       (rst),
    .acvalid          (acvalid),
    .acready          (acready),
    .acaddr           (acaddr),
    .acsnoop          (acsnoop),
    .crvalid          (crvalid),
    .crready          (crready),
    .crresp           (crresp),
    .cdvalid          (cdvalid),
    .cdready          (cdready),
    .cddata           (cddata),
    .cdlast           (cdlast),
    .i_enable         (i_enable),
    .i_mode           (i_mode),
    .i_shot_count     (i_shot_count),
    .i_crresp         (i_crresp),
    .i_delay          (i_delay),
    .i_data_pattern   (i_data_pattern),
    .i_snoop_match    (i_snoop_match),
    .i_snoop_match_en (i_snoop_match_en),
    .i_region_base    (i_region_base),
    .i_region_size    (i_region_size),
    .i_region_en      (i_region_en),
    .o_done           (o_done),
    .o_inject_count   (o_inject_count),
    .o_state          (o_state),
    .o_max_latency    (o_max_latency)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  resp;
    logic [31:0] pat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        data_pending = 1'b0;
  int          beat_exp = 0;
  logic [31:0] cur_pat = '0;
  int          t_hs = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] exp_beat(input logic [31:0] p, input int b);
    logic [127:0] d;
    d = {4{p}};
    d[7:0] = b[7:0];
    return d;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      data_pending = 1'b0;
    end else begin
      if (crvalid && crready) begin
        if (exp_q.size() == 0) begin
          check_val("cr_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("crresp", crresp, mon_e.resp);
          if (mon_e.resp[0]) begin
            data_pending = 1'b1;
            beat_exp = 0;
            cur_pat = mon_e.pat;
          end
        end
      end
      if (cdvalid && cdready) begin
        if (!data_pending) begin
          check_val("cd_unexpected", 1, 0);
        end else begin
          check_val("cddata", cddata, exp_beat(cur_pat, beat_exp));
          check_val("cdlast", cdlast, beat_exp == 3);
          beat_exp++;
          if (beat_exp == 4) data_pending = 1'b0;
        end
      end
    end
  end

  task automatic send_ac(input logic [AW-1:0] a, input logic [3:0] s, input logic [4:0] er);
    exp_t e;
    bit got;
    e.resp = er;
    e.pat = i_data_pattern;
    exp_q.push_back(e);
    acaddr = a;
    acsnoop = s;
    acvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (acready) begin
        got = 1;
        t_hs = cyc;
      end
    end
    if (!got) check_val("ac_timeout", 0, 1);
    @(posedge clk);
    #1 acvalid = 1'b0;
  endtask

  task automatic wait_cr(input int exp_lat, input int stall, input logic [4:0] er);
    bit got;
    got = 0;
    crready = (stall == 0);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (crvalid) got = 1;
    end
    if (!got) check_val("cr_timeout", 0, 1);
    else check_val("cr_latency", cyc - t_hs, exp_lat);
    for (int i = 0; i < stall; i++) begin
      check_val("cr_hold", {crvalid, crresp}, {1'b1, er});
      @(posedge clk);
      #1;
    end
    crready = 1'b1;
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (acready) got = 1;
    end
    if (!got) check_val("idle_timeout", 0, 1);
    check_val("beats_left", data_pending, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic snoop(input logic [AW-1:0] a, input logic [3:0] s, input logic [4:0] er,
                       input int lat);
    send_ac(a, s, er);
    wait_cr(lat, 0, er);
    wait_idle();
  endtask

  task automatic clear_shots();
    i_enable = 1'b0;
    @(posedge clk);
    #1 i_enable = 1'b1;
    check_val("clr_done", o_done, 0);
    check_val("clr_count", o_inject_count, 0);
  endtask

  task automatic check_reset_vals();
    check_val("rst_acready", acready, 0);
    check_val("rst_crvalid", crvalid, 0);
    check_val("rst_crresp", crresp, 0);
    check_val("rst_cdvalid", cdvalid, 0);
    check_val("rst_cdlast", cdlast, 0);
    check_val("rst_cddata", cddata, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_count", o_inject_count, 0);
    check_val("rst_state", o_state, 0);
    check_val("rst_maxlat", o_max_latency, 0);
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    acvalid = 1'b0; acaddr = '0; acsnoop = '0;
    crready = 1'b1; cdready = 1'b1;
    i_enable = 1'b0; i_mode = 2'd0; i_shot_count = '0; i_crresp = '0; i_delay = '0;
    i_data_pattern = '0; i_snoop_match = '0; i_snoop_match_en = 1'b0;
    i_region_base = '0; i_region_size = '0; i_region_en = '0;

    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst = 1'b0;
    @(posedge clk);
    #1 check_val("acready_after_rst", acready, 1);

    // One-shot with data
    i_enable = 1'b1; i_mode = 2'd1;
    i_region_base[31:0] = 32'h0000_1000; i_region_size[31:0] = 32'h0000_0100;
    i_region_en = 4'b0001; i_crresp = 5'h01; i_delay = '0;
    i_data_pattern = 32'hA5C3_5A3C;
    snoop(44'h1040, 4'h0, 5'h01, 2);
    check_val("oneshot_done", o_done, 1);
    check_val("oneshot_count", o_inject_count, 1);
    snoop(44'h1040, 4'h0, 5'h00, 2);
    check_val("oneshot_count2", o_inject_count, 1);

    // N-shot, budget 3
    clear_shots();
    i_mode = 2'd2; i_shot_count = 8'd3; i_crresp = 5'h08;
    for (int i = 0; i < 5; i++) snoop(44'h1080, 4'h0, (i < 3) ? 5'h08 : 5'h00, 2);
    check_val("nshot_count", o_inject_count, 3);
    check_val("nshot_done", o_done, 1);

    // Window boundaries, continuous mode
    clear_shots();
    i_mode = 2'd3; i_crresp = 5'h02;
    i_region_base[63:32] = 32'hFFFF_FF00; i_region_size[63:32] = 32'h0000_0200;
    i_region_en = 4'b0011;
    snoop(44'h10FF, 4'h0, 5'h02, 2);
    snoop(44'h1100, 4'h0, 5'h00, 2);
    snoop(44'h1000, 4'h0, 5'h02, 2);
    snoop(44'h0FFF, 4'h0, 5'h00, 2);
    snoop(44'h0AB_FFFF_FFF0, 4'h0, 5'h02, 2);
    snoop(44'h000_0000_0010, 4'h0, 5'h00, 2);
    i_region_en = 4'b0010;
    snoop(44'h1040, 4'h0, 5'h00, 2);
    i_region_en = 4'b0011;
    check_val("cont_done", o_done, 0);

    // Delay 10 with a 3-cycle CR stall
    i_crresp = 5'h04; i_delay = 16'd10;
    send_ac(44'h1040, 4'h0, 5'h04);
    wait_cr(12, 3, 5'h04);
    wait_idle();
    i_delay = '0;

    // Snoop-type filter
    i_snoop_match_en = 1'b1; i_snoop_match = 4'h7; i_crresp = 5'h09;
    i_data_pattern = 32'h0F1E_2D3C;
    snoop(44'h1040, 4'h7, 5'h09, 2);
    snoop(44'h1040, 4'h1, 5'h00, 2);
    check_val("filter_done", o_done, 0);
    check_val("filter_count", o_inject_count, 5);
    i_snoop_match_en = 1'b0;

    // N-shot with zero budget
    clear_shots();
    i_mode = 2'd2; i_shot_count = 8'd0; i_crresp = 5'h08;
    snoop(44'h1040, 4'h0, 5'h00, 2);
    check_val("zero_shot_done", o_done, 1);
    check_val("zero_shot_count", o_inject_count, 0);

    // Reset during data beat 2
    clear_shots();
    i_mode = 2'd3; i_crresp = 5'h01; i_data_pattern = 32'h1234_5678;
    send_ac(44'h1040, 4'h0, 5'h01);
    wait_cr(2, 0, 5'h01);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cdvalid && cddata[7:0] == 8'd2) got = 1;
    end
    if (!got) check_val("beat2_timeout", 0, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_reset_vals();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    snoop(44'h1040, 4'h0, 5'h01, 2);
    check_val("post_rst_count", o_inject_count, 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snoop_fault_injector.md
# snoop_fault_injector

Parametrised ACE snoop-channel responder that answers every AC request with a CR response and optional CD data. Requests that match a configurable snoop-type filter and any of NUM_REGIONS address windows receive an injected response: programmable CRRESP, delay and data pattern, in one-shot, N-shot or continuous mode. All other requests receive a clean, immediate reply. It sits between the ACE slave snoop port and the AXI-Lite register file, and is the multi-region, multi-shot successor to the single-window devil FSM.

## Interface
- C_ACE_ADDR_WIDTH, 44, AC address width
- C_ACE_DATA_WIDTH, 128, CD data width; must divide 512
- LINE_BYTES, 64, cache line size; BEATS = LINE_BYTES*8/C_ACE_DATA_WIDTH
- NUM_REGIONS, 4, number of address windows (1..8)
- DELAY_WIDTH, 16, width of the injected-delay counter
- SHOT_WIDTH, 8, width of the shot and inject counters

Ports:
- ace_aclk  in  1  clock; everything is on the rising edge
- ace_areset  in  1  synchronous, active-high reset
- acvalid / acready  in / out  1 / 1  AC handshake
- acaddr  in  C_ACE_ADDR_WIDTH  snoop address
- acsnoop  in  4  snoop type
- crvalid / crready  out / in  1 / 1  CR handshake
- crresp  out  5  snoop response
- cdvalid / cdready  out / in  1 / 1  CD handshake
- cddata  out  C_ACE_DATA_WIDTH  snoop data
- cdlast  out  1  final CD beat
- i_enable  in  1  injection enable; a low level clears o_done and o_inject_count
- i_mode  in  2  0 off, 1 one-shot, 2 N-shot, 3 continuous
- i_shot_count  in  SHOT_WIDTH  injections allowed in N-shot mode
- i_crresp  in  5  injected CRRESP
- i_delay  in  DELAY_WIDTH  cycles inserted before the injected CR
- i_data_pattern  in  32  injected data word
- i_snoop_match, i_snoop_match_en  in  4, 1  snoop-type filter
- i_region_base, i_region_size  in  NUM_REGIONS*32 each  window base and size on addr[31:0]
- i_region_en  in  NUM_REGIONS  per-window enable
- o_done  out  1  shot budget exhausted
- o_inject_count  out  SHOT_WIDTH  injected responses; saturating
- o_state  out  3  FSM state for debug
- o_max_latency  out  DELAY_WIDTH+2  see Configuration

## Operation
- FSM states are IDLE, FILTER, DELAY, RESP, DATA.
- IDLE:
  - acready=1, registered from the state.
  - On acvalid&&acready, latch acaddr, acsnoop and all i_* configuration, then go to FILTER.
  - Configuration changes mid-transaction have no effect until the next handshake.
- FILTER:
  - Region hit: the region is enabled and base <= addr[31:0] < base+size, with the sum computed in 33 bits so the window never wraps. Size 0 never hits.
  - Snoop hit: !match_en || acsnoop == match.
  - inject = enable && mode != 0 && !o_done && any region hit && snoop hit.
  - inject → DELAY with counter=0; otherwise → RESP with a clean response (crresp=0).
- DELAY:
  - The counter increments each cycle.
  - When counter == latched i_delay, go to RESP; delay 0 costs no extra cycle.
- RESP:
  - crvalid=1, crresp held stable until crready.
  - On the handshake: if crresp[0] (DataTransfer) → DATA; else → IDLE.
  - An injected handshake increments o_inject_count (saturating at all-ones).
  - o_done sets on: one-shot after 1 injection; N-shot when the count reaches i_shot_count.
- Shot limits: N-shot with i_shot_count==0 means o_done is set on the first FILTER and no injection occurs. Continuous mode never sets o_done.
- DATA:
  - BEATS beats; cddata = i_data_pattern replicated, with cddata[7:0] = beat index.
  - cdlast is set on beat BEATS-1. Beats advance only on cdready; the last handshake → IDLE.
  - Clean replies never carry data.
- i_enable low in any state: the current transaction still completes (protocol safety), and subsequent snoops get clean replies.

## Timing
- Reset values: acready=0 during reset and 1 in the first cycle after; crvalid=cdvalid=cdlast=0, crresp=0, cddata=0, o_done=0, o_inject_count=0, o_state=IDLE, o_max_latency=0.
- CR latency: with the AC handshake in cycle T, crvalid rises at T+2 for a clean reply and at T+2+D for an injected reply with delay D.
- First cdvalid is in the cycle after the CR handshake.
- acready re-asserts in the cycle after the final CR or CD handshake, so there is at most one outstanding snoop.
- Outputs are registered; crvalid and cdvalid never drop without their handshake.
- Reset mid-transaction aborts immediately to reset values.

## Configuration
- SNOOP_INJ_LATENCY_STATS_EN defined: o_max_latency tracks the maximum number of cycles from AC handshake to CR handshake over all snoops. It saturates, and clears on reset or when i_enable falls.
- Undefined: o_max_latency is tied to 0 and no counter logic is built.

## Structure
- snoop_inj_pkg holds the state enum, the mode encodings (MODE_OFF/ONESHOT/NSHOT/CONT) and the CRRESP bit indices (DataTransfer=0, Error=1, PassDirty=2, IsShared=3, WasUnique=4).
- One sub-module, snoop_region_match: combinational NUM_REGIONS-way window compare producing a hit vector and an any-hit flag.

## Test plan
- Mode 1, region0 base 0x1000 size 0x100, i_crresp 0x01, delay 0; snoops at 0x1040 then 0x1040 → first: crvalid at T+2, crresp 0x01, 4 beats, byte0 0..3, cdlast on beat 3, o_done=1; second: crresp 0.
- Mode 2, shot_count 3, i_crresp 0x08; 5 hitting snoops → 3 with crresp 0x08, 2 with crresp 0; o_inject_count=3.
- Snoop at 0x10FF hits, snoop at 0x1100 misses; base 0xFFFFFF00 with size 0x200 hits 0xFFFFFFF0 and does not match 0x00000010.
- i_delay 10 with crready stalled 3 cycles → crvalid at T+12, held stable 3 cycles.
- Mode 3, i_snoop_match_en=1, match 0x7; acsnoop 0x7 → injected; acsnoop 0x1 → clean; o_done stays 0.
- Reset asserted during DATA beat 2 → next cycle all outputs at reset values; after release, a new snoop is served normally.
